// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue: MIPS32 fetch/prefetch stage that owns the PC, drives a 1-cycle synchronous imem and queues words downstream.
// Ports: clk/rst_n (async active-low); o_imem_req/o_imem_addr/i_imem_rdata to instruction memory;
// i_redirect_valid/i_redirect_pc flush and restart fetch; o_instr_valid/o_instr/o_instr_pc/i_instr_ready
// deliver the queue head; o_halted is sticky after HLT is delivered; o_occupancy is the queue fill level.
// Optional macro FETCH_STATS_EN adds saturating o_perf_fetched/o_perf_flushed counters.
module mips32_fetch_queue #(
    parameter int         AW     = 10,
    parameter int         DEPTH  = 4,
    parameter logic [5:0] HLT_OP = 6'h3f
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     o_imem_req,
    output logic [AW-1:0]            o_imem_addr,
    input  logic [31:0]              i_imem_rdata,
    input  logic                     i_redirect_valid,
    input  logic [AW-1:0]            i_redirect_pc,
    output logic                     o_instr_valid,
    output logic [31:0]              o_instr,
    output logic [AW-1:0]            o_instr_pc,
    input  logic                     i_instr_ready,
    output logic                     o_halted,
    output logic [$clog2(DEPTH):0]   o_occupancy
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]              o_perf_fetched,
    output logic [15:0]              o_perf_flushed
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    state_t         r_state;
    logic [AW-1:0]  r_fetch_pc;
    logic           r_inflight;
    logic [AW-1:0]  r_inflight_pc;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_pcq [DEPTH];
    logic           w_valid;
    logic           w_pop;
    logic           w_hlt_pop;
    logic           w_redir;
    logic [CW:0]    w_credit;
    logic           w_req;
    logic           w_push;
    logic           w_hlt_push;
    assign w_valid    = (r_count != '0) && (r_state != HALT);
    assign w_pop      = w_valid && i_instr_ready;
    assign w_hlt_pop  = w_pop && (r_state == DRAIN) && (r_mem[r_rptr][31:26] == HLT_OP);
    // an HLT pop beats a simultaneous redirect
    assign w_redir    = i_redirect_valid && (r_state != HALT) && !w_hlt_pop;
    // queued + in-flight words, net of this cycle's pop, must leave room for the new response
    assign w_credit   = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    // no request during a redirect cycle, so no stale response needs tracking afterwards
    assign w_req      = rst_n && (r_state == RUN) && !w_redir && (w_credit < (CW+1)'(DEPTH));
    assign w_push     = r_inflight && !w_redir;
    assign w_hlt_push = w_push && (r_state == RUN) && (i_imem_rdata[31:26] == HLT_OP);
    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_fetch_pc;
    assign o_instr_valid = w_valid;
    assign o_instr       = w_valid ? r_mem[r_rptr] : '0;
    assign o_instr_pc    = w_valid ? r_pcq[r_rptr] : '0;
    assign o_halted      = (r_state == HALT);
    assign o_occupancy   = r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_fetch_pc    <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_hlt_pop ? HALT : w_redir ? RUN : w_hlt_push ? DRAIN : r_state;
            r_fetch_pc    <= w_redir ? i_redirect_pc : w_req ? r_fetch_pc + AW'(1) : r_fetch_pc;
            // a request issued alongside the HLT push is squashed here
            r_inflight    <= w_req && !w_hlt_push;
            r_inflight_pc <= r_fetch_pc;
            r_wptr        <= w_redir ? '0 : r_wptr + PW'(w_push);
            r_rptr        <= w_redir ? '0 : r_rptr + PW'(w_pop);
            r_count       <= w_redir ? '0 : r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_imem_rdata;
            r_pcq[r_wptr] <= r_inflight_pc;
        end
    end
`ifdef FETCH_STATS_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_flushed;
    logic [CW:0] w_flush_n;
    logic [16:0] w_fetched_sum;
    logic [16:0] w_flushed_sum;
    // redirect discards what stays queued plus the word arriving now; HLT squashes the request issued with it
    assign w_flush_n     = w_redir ? {1'b0, r_count} - (CW+1)'(w_pop) + (CW+1)'(r_inflight)
                                   : (CW+1)'(w_hlt_push && w_req);
    assign w_fetched_sum = {1'b0, r_perf_fetched} + 17'(w_push);
    assign w_flushed_sum = {1'b0, r_perf_flushed} + 17'(w_flush_n);
    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_flushed = r_perf_flushed;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= w_fetched_sum[16] ? 16'hffff : w_fetched_sum[15:0];
            r_perf_flushed <= w_flushed_sum[16] ? 16'hffff : w_flushed_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb_mips32_fetch_queue: directed bench for mips32_fetch_queue (AW=10 main instance, AW=4 wrap instance).
module tb_mips32_fetch_queue;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n;
    logic        req;
    logic [9:0]  addr;
    logic [31:0] rdata = '0;
    logic        redir;
    logic [9:0]  redir_pc;
    logic        valid;
    logic [31:0] instr;
    logic [9:0]  ipc;
    logic        ready;
    logic        halted;
    logic [2:0]  occ;
    logic        req2;
    logic [3:0]  addr2;
    logic [31:0] rdata2 = '0;
    logic        redir2;
    logic [3:0]  redir2_pc;
    logic        valid2;
    logic [31:0] instr2;
    logic [3:0]  ipc2;
    logic        ready2;
    logic        halted2;
    logic [2:0]  occ2;
`ifdef FETCH_STATS_EN
    logic [15:0] pf, pfl, pf2, pfl2;
`endif
    logic [31:0] mem  [16];
    logic [31:0] mem2 [16];
    int n_chk = 0;
    int n_bad = 0;

    mips32_fetch_queue #(.AW(10), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_rdata(rdata),
        .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .o_instr_valid(valid), .o_instr(instr), .o_instr_pc(ipc), .i_instr_ready(ready),
        .o_halted(halted), .o_occupancy(occ)
`ifdef FETCH_STATS_EN
        , .o_perf_fetched(pf), .o_perf_flushed(pfl)
`endif
    );

    mips32_fetch_queue #(.AW(4), .DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_rdata(rdata2),
        .i_redirect_valid(redir2), .i_redirect_pc(redir2_pc),
        .o_instr_valid(valid2), .o_instr(instr2), .o_instr_pc(ipc2), .i_instr_ready(ready2),
        .o_halted(halted2), .o_occupancy(occ2)
`ifdef FETCH_STATS_EN
        , .o_perf_fetched(pf2), .o_perf_flushed(pfl2)
`endif
    );

    always @(posedge clk) if (req)  rdata  <= mem[addr[3:0]];
    always @(posedge clk) if (req2) rdata2 <= mem2[addr2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},    32'(req),    0);
        chk({tag, "_addr"},   32'(addr),   0);
        chk({tag, "_valid"},  32'(valid),  0);
        chk({tag, "_instr"},  instr,       0);
        chk({tag, "_pc"},     32'(ipc),    0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_occ"},    32'(occ),    0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0; redir = 1'b0; redir_pc = '0;
        ready2 = 1'b0; redir2 = 1'b0; redir2_pc = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int n, hi, halt_c, nr, st;
        logic [9:0] got [8];
        logic [9:0] exp4 [6];
        mem = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800, 32'h00222000,
                32'h0ce77800, 32'h00832800, 32'hfc000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 16; i++) mem2[i] = 32'h24000000 | 32'(i);
        exp4 = '{10'd0, 10'd1, 10'd2, 10'd6, 10'd7, 10'd8};
        ready = 1'b0; redir = 1'b0; redir_pc = '0;
        ready2 = 1'b0; redir2 = 1'b0; redir2_pc = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset("rst0");

        // streaming program with ready held high, ending in HLT
        do_reset();
        ready = 1'b1;
        #1;
        n = 0; hi = 0; halt_c = -1;
        for (int c = 0; c < 16; c++) begin
            if (req && addr > 10'd9) hi++;
            if (halted && halt_c < 0) halt_c = c;
            if (valid && ready) begin
                chk("t1_pc", 32'(ipc), 32'(n));
                chk("t1_instr", instr, mem[n]);
                chk("t1_cycle", 32'(c), 32'(n + 2));
                n++;
            end
            tick();
        end
        chk("t1_count", 32'(n), 9);
        chk("t1_hi_addr", 32'(hi), 0);
        chk("t1_halt_cycle", 32'(halt_c), 11);
        chk("t1_halt_req", 32'(req), 0);
        redir = 1'b1; redir_pc = 10'd3;
        #1;
        chk("t1_halt_redir_req", 32'(req), 0);
        tick();
        redir = 1'b0;
        #1;
        chk("t1_halt_sticky", 32'(halted), 1);
        chk("t1_halt_valid", 32'(valid), 0);

        // backpressure: queue fills to DEPTH and stalls
        do_reset();
        nr = 0; st = 0;
        for (int c = 0; c < 10; c++) begin
            if (req) nr++;
            if (c >= 2 && (!valid || instr != mem[0])) st++;
            tick();
        end
        chk("t2_occ", 32'(occ), 4);
        chk("t2_instr", instr, mem[0]);
        chk("t2_req", 32'(req), 0);
        chk("t2_nreq", 32'(nr), 4);
        chk("t2_stable", 32'(st), 0);
        ready = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            chk("t2_valid", 32'(valid), 1);
            chk("t2_pc", 32'(ipc), 32'(k));
            tick();
        end

        // redirect with 3 queued and one in flight
        do_reset();
        repeat (4) tick();
        chk("t3_occ3", 32'(occ), 3);
        redir = 1'b1; redir_pc = 10'd5;
        #1;
        chk("t3_req_redir", 32'(req), 0);
        tick();
        redir = 1'b0; ready = 1'b1;
        #1;
        chk("t3_occ0", 32'(occ), 0);
        chk("t3_valid0", 32'(valid), 0);
        chk("t3_req", 32'(req), 1);
        chk("t3_addr", 32'(addr), 5);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (valid && ready && n < 4) begin
                chk("t3_pc", 32'(ipc), 32'(5 + n));
                if (n == 0) chk("t3_instr", instr, 32'h00222000);
                n++;
            end
            tick();
        end
        chk("t3_count", 32'(n), 4);

        // redirect coinciding with the handshake of pc 2
        do_reset();
        ready = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 4) begin redir = 1'b1; redir_pc = 10'd6; #1; end
            if (c == 5) begin
                redir = 1'b0;
                #1;
                chk("t4_occ_flush", 32'(occ), 0);
            end
            if (valid && ready && n < 8) begin got[n] = ipc; n++; end
            tick();
        end
        chk("t4_count", 32'(n), 6);
        for (int i = 0; i < 6; i++) chk("t4_seq", 32'(got[i]), 32'(exp4[i]));

        // AW=4 wrap from 14
        do_reset();
        ready2 = 1'b1; redir2 = 1'b1; redir2_pc = 4'd14;
        #1;
        tick();
        redir2 = 1'b0;
        #1;
        n = 0;
        for (int c = 1; c < 9; c++) begin
            if (valid2 && n < 4) begin
                chk("t5_pc", 32'(ipc2), 32'((14 + n) % 16));
                chk("t5_instr", instr2, mem2[(14 + n) % 16]);
                n++;
            end
            tick();
        end
        chk("t5_count", 32'(n), 4);

        // reset asserted in DRAIN with two entries queued
        do_reset();
        redir = 1'b1; redir_pc = 10'd7;
        #1;
        tick();
        redir = 1'b0;
        #1;
        repeat (3) tick();
        chk("t6_occ", 32'(occ), 2);
        chk("t6_req", 32'(req), 0);
        chk("t6_pc", 32'(ipc), 7);
        chk("t6_instr", instr, 32'h00832800);
        tick();
        chk("t6_occ_hold", 32'(occ), 2);
        chk("t6_req_hold", 32'(req), 0);
        rst_n = 1'b0;
        #1;
        check_reset("t6_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ready = 1'b1;
        #1;
        chk("t6_restart_req", 32'(req), 1);
        chk("t6_restart_addr", 32'(addr), 0);
        chk("t6_restart_halted", 32'(halted), 0);
        tick();
        tick();
        chk("t6_restart_valid", 32'(valid), 1);
        chk("t6_restart_pc", 32'(ipc), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
